spi_xfer_queue: RTL and testbench

//  Byte-queue front end for the SPI master, on the processor side of it.

---
 rtl/spi_xfer_queue_pkg.sv | 11 +
 rtl/sync_fifo.sv | 49 ++++
 rtl/spi_xfer_queue.sv | 125 ++++++++++++
 tb/tb_spi_xfer_queue.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_xfer_queue_pkg.sv
// rtl/spi_xfer_queue_pkg.sv - shared widths and FSM state encodings for the SPI byte queue
package spi_xfer_queue_pkg;

    localparam int BYTE_W = 8;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_REQ     = 2'd1;
    localparam logic [1:0] ST_XFER    = 2'd2;
    localparam logic [1:0] ST_CAPTURE = 2'd3;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - first-word fall-through FIFO with AW+1 bit wrapping pointers
module sync_fifo
    import spi_xfer_queue_pkg::*;
#(
    parameter int W         = BYTE_W,
    parameter int DEPTH     = 8,
    parameter int AW        = 3,
    // When set, a push into a full FIFO succeeds if a pop is taken in the same cycle.
    parameter bit FULL_PASS = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    output logic [W-1:0]  dout,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wptr;
    logic [AW:0]  rptr;
    logic         do_push;
    logic         do_pop;

    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign count   = wptr - rptr;
    assign dout    = mem[rptr[AW-1:0]];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || (FULL_PASS && do_pop));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/spi_xfer_queue.sv
// rtl/spi_xfer_queue.sv - TX/RX byte queues and exchange sequencer in front of the SPI master
module spi_xfer_queue
    import spi_xfer_queue_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int AW      = 3,
    parameter int REQ_TMO = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [BYTE_W-1:0] wr_data,
    output logic              tx_full,
    input  logic              rd_en,
    output logic [BYTE_W-1:0] rd_data,
    output logic              rx_empty,
    output logic [AW:0]       rx_count,
    output logic [BYTE_W-1:0] spi_data_in,
    output logic              spi_ready,
    input  logic              spi_ss,
    input  logic [BYTE_W-1:0] spi_data_out,
    output logic              busy,
    output logic              rx_ovf,
    output logic              req_tmo,
    input  logic              clr_err
);

    localparam int TW = $clog2(REQ_TMO + 1);

    logic [1:0]        state;
    logic [1:0]        state_d;
    logic              ss_s1;
    logic              ss_s2;
    logic [TW-1:0]     tmo_cnt;
    logic [BYTE_W-1:0] tx_dout;
    logic              tx_empty;
    logic [AW:0]       tx_count;
    logic [AW:0]       tx_cnt_d;
    logic              rx_full;
    logic              tx_pop;
    logic              tx_push_ok;
    logic              rx_push;
    logic              ovf_set;
    logic              tmo_hit;

    assign tx_pop     = (state == ST_IDLE) && !tx_empty;
    assign tx_push_ok = wr_en && !tx_full;
    assign rx_push    = (state == ST_CAPTURE);
    // A full RX FIFO with rd_en this cycle still accepts the byte.
    assign ovf_set    = rx_push && rx_full && !rd_en;
    assign tmo_hit    = (state == ST_REQ) && ss_s2 && (tmo_cnt == TW'(REQ_TMO - 1));
    assign tx_cnt_d   = tx_count + (AW+1)'(tx_push_ok) - (AW+1)'(tx_pop);

    sync_fifo #(.W(BYTE_W), .DEPTH(DEPTH), .AW(AW), .FULL_PASS(1'b0)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (wr_en),
        .din   (wr_data),
        .pop   (tx_pop),
        .dout  (tx_dout),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_count)
    );

    sync_fifo #(.W(BYTE_W), .DEPTH(DEPTH), .AW(AW), .FULL_PASS(1'b1)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_push),
        .din   (spi_data_out),
        .pop   (rd_en),
        .dout  (rd_data),
        .full  (rx_full),
        .empty (rx_empty),
        .count (rx_count)
    );

    always_comb begin
        state_d = state;
        case (state)
            ST_IDLE:    if (tx_pop) state_d = ST_REQ;
            ST_REQ:     if (!ss_s2) state_d = ST_XFER;
                        else if (tmo_hit) state_d = ST_IDLE;
            ST_XFER:    if (ss_s2) state_d = ST_CAPTURE;
            ST_CAPTURE: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            ss_s1       <= 1'b1;
            ss_s2       <= 1'b1;
            tmo_cnt     <= '0;
            spi_ready   <= 1'b0;
            spi_data_in <= '0;
            busy        <= 1'b0;
            rx_ovf      <= 1'b0;
            req_tmo     <= 1'b0;
        end else begin
            ss_s1   <= spi_ss;
            ss_s2   <= ss_s1;
            state   <= state_d;
            busy    <= (state_d != ST_IDLE) || (tx_cnt_d != '0);
            rx_ovf  <= ovf_set || (rx_ovf && !clr_err);
            req_tmo <= tmo_hit || (req_tmo && !clr_err);
            case (state)
                ST_IDLE: begin
                    if (tx_pop) begin
                        spi_data_in <= tx_dout;
                        spi_ready   <= 1'b1;
                        tmo_cnt     <= '0;
                    end
                end
                ST_REQ: begin
                    if (!ss_s2 || tmo_hit) spi_ready <= 1'b0;
                    else                   tmo_cnt   <= tmo_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_xfer_queue.sv
// tb/tb_spi_xfer_queue.sv - self-checking bench with queue model and behavioural SPI master
module tb_spi_xfer_queue;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       tx_full;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       rx_empty;
    logic [3:0] rx_count;
    logic [7:0] spi_data_in;
    logic       spi_ready;
    logic       spi_ss;
    logic [7:0] spi_data_out;
    logic       busy;
    logic       rx_ovf;
    logic       req_tmo;
    logic       clr_err;

    int errs   = 0;
    int checks = 0;

    logic [7:0] m_tx[$];
    logic [7:0] m_rx[$];
    int         cap_t[$];
    logic [7:0] cap_b[$];
    bit         m_ovf = 1'b0;
    int         cyc = 0;
    bit         chk_en = 1'b0;
    bit         master_en = 1'b1;

    spi_xfer_queue #(.DEPTH(8), .AW(3), .REQ_TMO(64)) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .tx_full      (tx_full),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .rx_empty     (rx_empty),
        .rx_count     (rx_count),
        .spi_data_in  (spi_data_in),
        .spi_ready    (spi_ready),
        .spi_ss       (spi_ss),
        .spi_data_out (spi_data_out),
        .busy         (busy),
        .rx_ovf       (rx_ovf),
        .req_tmo      (req_tmo),
        .clr_err      (clr_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: RX queue and overflow flag advance at the clock edge where the byte lands.
    initial begin : model_blk
        logic [7:0] b;
        bit         set;
        forever begin
            @(posedge clk);
            cyc++;
            if (rst) begin
                m_rx.delete();
                cap_t.delete();
                cap_b.delete();
                m_ovf = 1'b0;
            end else begin
                set = 1'b0;
                if (rd_en && m_rx.size() > 0) void'(m_rx.pop_front());
                if (cap_t.size() > 0 && cap_t[0] == cyc) begin
                    void'(cap_t.pop_front());
                    b = cap_b.pop_front();
                    if (m_rx.size() < 8) m_rx.push_back(b);
                    else                 set = 1'b1;
                end
                if (set)          m_ovf = 1'b1;
                else if (clr_err) m_ovf = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("rx_count", rx_count, m_rx.size());
            chk("rx_empty", rx_empty, m_rx.size() == 0);
            if (m_rx.size() > 0) chk("rd_data", rd_data, m_rx[0]);
            chk("rx_ovf", rx_ovf, m_ovf);
        end
    end

    // Behavioural master: answers spi_ready with a 12-cycle ss-low exchange, loops the byte back.
    initial begin : master_blk
        int         ph;
        int         cnt;
        logic [7:0] mb;
        ph = 0; cnt = 0; mb = 8'h00;
        spi_ss = 1'b1;
        spi_data_out = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                spi_ss = 1'b1;
                ph = 0;
            end else begin
                case (ph)
                    0: if (master_en && spi_ready === 1'b1) begin cnt = 2; ph = 1; end
                    1: begin
                        cnt--;
                        if (cnt == 0) begin
                            spi_ss = 1'b0;
                            chk("tx_model_nonempty", m_tx.size() > 0, 1);
                            if (m_tx.size() > 0) begin
                                mb = m_tx.pop_front();
                                chk("spi_data_in", spi_data_in, mb);
                            end
                            cnt = 12;
                            ph = 2;
                        end
                    end
                    2: begin
                        cnt--;
                        if (cnt == 0) begin
                            spi_data_out = mb;
                            spi_ss = 1'b1;
                            cap_t.push_back(cyc + 4);
                            cap_b.push_back(mb);
                            ph = 0;
                        end
                    end
                    default: ph = 0;
                endcase
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] d, input bit acc);
        chk("tx_full_before_wr", tx_full, !acc);
        wr_data = d;
        wr_en = 1'b1;
        step();
        wr_en = 1'b0;
        if (acc) m_tx.push_back(d);
    endtask

    task automatic rd();
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
    endtask

    initial begin : main_blk
        int n;
        int nr;
        int tgt;
        bit saw;
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; wr_data = 8'h00;
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;
        @(negedge clk);
        chk("rst_tx_full", tx_full, 0);
        chk("rst_rx_empty", rx_empty, 1);
        chk("rst_rx_count", rx_count, 0);
        chk("rst_spi_ready", spi_ready, 0);
        chk("rst_spi_data_in", spi_data_in, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rx_ovf", rx_ovf, 0);
        chk("rst_req_tmo", req_tmo, 0);
        chk_en = 1'b1;
        step();

        // single loopback byte
        saw = 1'b0;
        wr(8'hA5, 1'b1);
        n = 0;
        while (rx_count != 4'd1 && n < 300) begin
            if (spi_ready) saw = 1'b1;
            step(); n++;
        end
        chk("t1_wait", n < 300, 1);
        chk("t1_saw_ready", saw, 1);
        chk("t1_rd_data", rd_data, 8'hA5);
        chk("t1_rx_count", rx_count, 1);
        rd();
        chk("t1_drained", rx_empty, 1);

        // request timeout with ss held high
        master_en = 1'b0;
        wr(8'h55, 1'b1);
        n = 0;
        while (spi_ready !== 1'b1 && n < 50) begin step(); n++; end
        nr = 0;
        while (spi_ready === 1'b1 && nr < 200) begin step(); nr++; end
        chk("t4_req_cycles", nr, 64);
        chk("t4_req_tmo", req_tmo, 1);
        chk("t4_busy", busy, 0);
        void'(m_tx.pop_front());
        pulse_clr();
        chk("t4_req_tmo_clr", req_tmo, 0);

        // fill TX while the FSM is parked in REQ on a sacrificial byte
        wr(8'hEE, 1'b1);
        repeat (3) step();
        for (int i = 1; i <= 8; i++) wr(8'(i), 1'b1);
        wr(8'h09, 1'b0);
        chk("t2_tx_full", tx_full, 1);
        chk("t2_busy", busy, 1);
        n = 0;
        while (req_tmo !== 1'b1 && n < 200) begin step(); n++; end
        chk("t2_tmo_wait", n < 200, 1);
        void'(m_tx.pop_front());
        master_en = 1'b1;
        pulse_clr();
        n = 0;
        while ((rx_count != 4'd8 || busy) && n < 800) begin step(); n++; end
        chk("t2_rx_wait", n < 800, 1);
        chk("t2_rd_data", rd_data, 8'h01);
        chk("t2_tx_full_after", tx_full, 0);
        chk("t2_req_tmo", req_tmo, 0);

        // RX overflow
        wr(8'h3C, 1'b1);
        n = 0;
        while (busy && n < 200) begin step(); n++; end
        chk("t3_busy_wait", n < 200, 1);
        chk("t3_rx_ovf", rx_ovf, 1);
        chk("t3_rx_count", rx_count, 8);
        pulse_clr();
        chk("t3_rx_ovf_clr", rx_ovf, 0);
        chk("t3_rd_data", rd_data, 8'h01);

        // rd_en coinciding with CAPTURE on a full RX FIFO
        wr(8'h4B, 1'b1);
        n = 0;
        while (cap_t.size() == 0 && n < 200) begin step(); #1; n++; end
        chk("t6_cap_wait", n < 200, 1);
        if (cap_t.size() > 0) begin
            tgt = cap_t[0];
            while (cyc < tgt - 1) begin @(posedge clk); #2; end
            rd_en = 1'b1;
            @(posedge clk); #2;
            rd_en = 1'b0;
        end
        step();
        chk("t6_rx_count", rx_count, 8);
        chk("t6_rx_ovf", rx_ovf, 0);
        chk("t6_rd_data", rd_data, 8'h02);
        for (int i = 0; i < 8; i++) begin
            chk("drain_order", rd_data, (i < 7) ? 8'(i + 2) : 8'h4B);
            rd();
        end
        chk("drain_empty", rx_empty, 1);

        // reset mid-exchange
        wr(8'h66, 1'b1);
        n = 0;
        while (spi_ss !== 1'b0 && n < 100) begin step(); n++; end
        chk("t5_ss_wait", n < 100, 1);
        repeat (3) step();
        #2 rst = 1'b1;
        m_tx.delete(); m_rx.delete(); cap_t.delete(); cap_b.delete(); m_ovf = 1'b0;
        #1;
        chk("t5_spi_ready", spi_ready, 0);
        chk("t5_busy", busy, 0);
        chk("t5_spi_data_in", spi_data_in, 0);
        chk("t5_rx_count", rx_count, 0);
        chk("t5_tx_full", tx_full, 0);
        chk("t5_req_tmo", req_tmo, 0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        step();
        wr(8'h77, 1'b1);
        n = 0;
        while (rx_count != 4'd1 && n < 300) begin step(); n++; end
        chk("t5_after_wait", n < 300, 1);
        chk("t5_rd_data", rd_data, 8'h77);
        repeat (3) step();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
